// File: rtl/taxi_eth_phy_rx_frame_sync_ml.sv
// Multi-lane BASE-R block sync.
// Each lane hunts for 2-bit sync headers independently, slips its SERDES
// on bad headers while unlocked, and tracks lock with a windowed
// invalid-header count once locked.

module taxi_eth_phy_rx_frame_sync_ml_lane #(
    parameter int SH_WIN              = 64,
    parameter int SH_INV_MAX          = 16,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 7,
    parameter int STAT_CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            hdr,
    input  logic                  hdr_valid,
    output logic                  bitslip,
    output logic                  block_lock,
    output logic                  lock_lost,
    output logic [STAT_CNT_W-1:0] loss_cnt
);

    localparam int CNT_W    = $clog2(SH_WIN);
    localparam int INV_W    = $clog2(SH_INV_MAX + 1);
    localparam int SLIP_TOT = BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES;
    localparam int SLIP_W   = $clog2(SLIP_TOT + 1);

    localparam logic [CNT_W-1:0]  WIN_LAST = CNT_W'(SH_WIN - 1);
    localparam logic [INV_W-1:0]  INV_LAST = INV_W'(SH_INV_MAX - 1);
    localparam logic [SLIP_W-1:0] SLIP_LD  = SLIP_W'(SLIP_TOT);
    localparam logic [SLIP_W-1:0] SLIP_LOW = SLIP_W'(BITSLIP_LOW_CYCLES);

    logic [CNT_W-1:0]  sh_count;
    logic [INV_W-1:0]  sh_inv_count;
    logic [SLIP_W-1:0] slip_cnt;

    logic hdr_ok;
    logic slip_busy;
    logic win_end;
    logic inv_last;

    assign hdr_ok    = hdr[0] ^ hdr[1];
    assign slip_busy = (slip_cnt != '0);
    assign win_end   = (sh_count == WIN_LAST);
    assign inv_last  = (sh_inv_count == INV_LAST);

    // Slip timer counts down through the high phase then the guard phase;
    // the pulse is high while the remaining count exceeds the guard length.
    assign bitslip = (slip_cnt > SLIP_LOW);

    // Lock tracking: slip span blocks headers, then unlocked hunt or locked window.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_count     <= '0;
            sh_inv_count <= '0;
            slip_cnt     <= '0;
            block_lock   <= 1'b0;
            lock_lost    <= 1'b0;
            loss_cnt     <= '0;
        end else begin
            lock_lost <= 1'b0;
            if (slip_busy) begin
                slip_cnt <= slip_cnt - SLIP_W'(1);
            end else if (hdr_valid) begin
                if (!block_lock) begin
                    if (!hdr_ok) begin
                        sh_count     <= '0;
                        sh_inv_count <= '0;
                        slip_cnt     <= SLIP_LD;
                    end else if (win_end) begin
                        block_lock   <= 1'b1;
                        sh_count     <= '0;
                        sh_inv_count <= '0;
                    end else begin
                        sh_count <= sh_count + CNT_W'(1);
                    end
                end else begin
                    // Lock loss outranks the window-end clear.
                    if (!hdr_ok && inv_last) begin
                        block_lock   <= 1'b0;
                        sh_count     <= '0;
                        sh_inv_count <= '0;
                        slip_cnt     <= SLIP_LD;
                        lock_lost    <= 1'b1;
                        if (loss_cnt != '1)
                            loss_cnt <= loss_cnt + STAT_CNT_W'(1);
                    end else if (win_end) begin
                        sh_count     <= '0;
                        sh_inv_count <= '0;
                    end else begin
                        sh_count <= sh_count + CNT_W'(1);
                        if (!hdr_ok)
                            sh_inv_count <= sh_inv_count + INV_W'(1);
                    end
                end
            end
        end
    end

endmodule

module taxi_eth_phy_rx_frame_sync_ml #(
    parameter int LANES               = 4,
    parameter int HDR_W               = 2,
    parameter int SH_WIN              = 64,
    parameter int SH_INV_MAX          = 16,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 7,
    parameter int STAT_CNT_W          = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES*HDR_W-1:0]      serdes_rx_hdr,
    input  logic [LANES-1:0]            serdes_rx_hdr_valid,
    output logic [LANES-1:0]            serdes_rx_bitslip,
    output logic [LANES-1:0]            rx_block_lock,
    output logic                        rx_block_lock_all,
    output logic [LANES-1:0]            stat_lock_lost,
    output logic [LANES*STAT_CNT_W-1:0] stat_lock_loss_cnt
);

    // Only 2-bit BASE-R sync headers are meaningful here.
    if (HDR_W != 2) begin : g_bad_hdr_w
        $fatal(1, "HDR_W must be 2");
    end

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        taxi_eth_phy_rx_frame_sync_ml_lane #(
            .SH_WIN              (SH_WIN),
            .SH_INV_MAX          (SH_INV_MAX),
            .BITSLIP_HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
            .BITSLIP_LOW_CYCLES  (BITSLIP_LOW_CYCLES),
            .STAT_CNT_W          (STAT_CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .hdr        (serdes_rx_hdr[n*HDR_W +: 2]),
            .hdr_valid  (serdes_rx_hdr_valid[n]),
            .bitslip    (serdes_rx_bitslip[n]),
            .block_lock (rx_block_lock[n]),
            .lock_lost  (stat_lock_lost[n]),
            .loss_cnt   (stat_lock_loss_cnt[n*STAT_CNT_W +: STAT_CNT_W])
        );
    end

    // Pure reduction of the registered lock bits: no added latency.
    assign rx_block_lock_all = &rx_block_lock;

endmodule

// File: tb/tb_taxi_eth_phy_rx_frame_sync_ml.sv
// Scoreboard bench: stimulus pushes expected output transitions (cycle,
// dut, lane, signal, value); a negedge monitor matches every observed
// transition against the queue and flags unexpected or missing ones.

module tb_taxi_eth_phy_rx_frame_sync_ml;

    localparam int K_LOCK = 0, K_SLIP = 1, K_LOST = 2, K_CNT = 3, K_ALL = 4;

    typedef struct {
        int cyc;
        int dut;
        int lane;
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 0;

    logic clk = 0;
    logic rst_a, rst_b;

    // DUT A: defaults
    logic [7:0]  hdr_a;
    logic [3:0]  hv_a, slip_a, lock_a, lost_a;
    logic        all_a;
    logic [31:0] cnt_a;

    // DUT B: 2 lanes, 2-bit stats, 4-cycle slip pulse
    logic [3:0]  hdr_b;
    logic [1:0]  hv_b, slip_b, lock_b, lost_b;
    logic        all_b;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    taxi_eth_phy_rx_frame_sync_ml u_dut_a (
        .clk(clk), .rst(rst_a),
        .serdes_rx_hdr(hdr_a), .serdes_rx_hdr_valid(hv_a),
        .serdes_rx_bitslip(slip_a), .rx_block_lock(lock_a),
        .rx_block_lock_all(all_a), .stat_lock_lost(lost_a),
        .stat_lock_loss_cnt(cnt_a)
    );

    taxi_eth_phy_rx_frame_sync_ml #(
        .LANES(2), .STAT_CNT_W(2), .BITSLIP_HIGH_CYCLES(4)
    ) u_dut_b (
        .clk(clk), .rst(rst_b),
        .serdes_rx_hdr(hdr_b), .serdes_rx_hdr_valid(hv_b),
        .serdes_rx_bitslip(slip_b), .rx_block_lock(lock_b),
        .rx_block_lock_all(all_b), .stat_lock_lost(lost_b),
        .stat_lock_loss_cnt(cnt_b)
    );

    // ---------------- scoreboard ----------------
    task automatic push(input int c, input int d, input int l, input int k, input int v);
        ev_t e;
        e.cyc = c; e.dut = d; e.lane = l; e.kind = k; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int d, input int l, input int k, input int v);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].dut == d &&
                exp_q[i].lane == l && exp_q[i].kind == k)
                idx = i;
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_change dut%0d lane%0d kind%0d cyc%0d got %0d want no change",
                     d, l, k, cyc, v);
        end else begin
            if (exp_q[idx].val != v) begin
                errors++;
                $display("FAIL value dut%0d lane%0d kind%0d cyc%0d got %0d want %0d",
                         d, l, k, cyc, v, exp_q[idx].val);
            end
            exp_q.delete(idx);
        end
    endtask

    task automatic reap(input int upto);
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].cyc < upto) begin
                checks++;
                errors++;
                $display("FAIL missing_change dut%0d lane%0d kind%0d cyc%0d got no change want %0d",
                         exp_q[i].dut, exp_q[i].lane, exp_q[i].kind, exp_q[i].cyc, exp_q[i].val);
                exp_q.delete(i);
            end
    endtask

    logic [3:0]  p_lock_a, p_slip_a, p_lost_a;
    logic        p_all_a;
    logic [31:0] p_cnt_a;
    logic [1:0]  p_lock_b, p_slip_b, p_lost_b;
    logic        p_all_b;
    logic [3:0]  p_cnt_b;

    // Monitor: any output transition must match a queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int l = 0; l < 4; l++) begin
                if (lock_a[l] !== p_lock_a[l]) observe(0, l, K_LOCK, int'(lock_a[l]));
                if (slip_a[l] !== p_slip_a[l]) observe(0, l, K_SLIP, int'(slip_a[l]));
                if (lost_a[l] !== p_lost_a[l]) observe(0, l, K_LOST, int'(lost_a[l]));
                if (cnt_a[l*8 +: 8] !== p_cnt_a[l*8 +: 8]) observe(0, l, K_CNT, int'(cnt_a[l*8 +: 8]));
            end
            if (all_a !== p_all_a) observe(0, 0, K_ALL, int'(all_a));
            for (int l = 0; l < 2; l++) begin
                if (lock_b[l] !== p_lock_b[l]) observe(1, l, K_LOCK, int'(lock_b[l]));
                if (slip_b[l] !== p_slip_b[l]) observe(1, l, K_SLIP, int'(slip_b[l]));
                if (lost_b[l] !== p_lost_b[l]) observe(1, l, K_LOST, int'(lost_b[l]));
                if (cnt_b[l*2 +: 2] !== p_cnt_b[l*2 +: 2]) observe(1, l, K_CNT, int'(cnt_b[l*2 +: 2]));
            end
            if (all_b !== p_all_b) observe(1, 0, K_ALL, int'(all_b));
            reap(cyc);
        end
        p_lock_a = lock_a; p_slip_a = slip_a; p_lost_a = lost_a; p_cnt_a = cnt_a; p_all_a = all_a;
        p_lock_b = lock_b; p_slip_b = slip_b; p_lost_b = lost_b; p_cnt_b = cnt_b; p_all_b = all_b;
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        hv_a = '0; hdr_a = '0;
        hv_b = '0; hdr_b = '0;
    endtask

    task automatic drv_a(input int l, input logic [1:0] h);
        hdr_a[l*2 +: 2] = h;
        hv_a[l] = 1'b1;
    endtask

    task automatic drv_b(input int l, input logic [1:0] h);
        hdr_b[l*2 +: 2] = h;
        hv_b[l] = 1'b1;
    endtask

    initial begin
        logic [1:0] h;
        rst_a = 1; rst_b = 1;
        hv_a = '0; hdr_a = '0; hv_b = '0; hdr_b = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_a_lock", int'(lock_a), 0);
        chk("rst_a_slip", int'(slip_a), 0);
        chk("rst_a_all",  int'(all_a),  0);
        chk("rst_a_lost", int'(lost_a), 0);
        chk("rst_a_cnt",  int'(cnt_a),  0);
        chk("rst_b_lock", int'(lock_b), 0);
        chk("rst_b_slip", int'(slip_b), 0);
        chk("rst_b_cnt",  int'(cnt_b),  0);
        rst_a = 0; rst_b = 0;
        mon_en = 1;
        tick();

        // 1: lane0 locks one cycle after its 64th valid header
        for (int i = 0; i < 64; i++) begin
            drv_a(0, 2'b01);
            if (i == 63) push(cyc + 1, 0, 0, K_LOCK, 1);
            tick();
        end
        chk("t1_lock0", int'(lock_a), 4'b0001);
        chk("t1_all",   int'(all_a),  0);

        // 2: lane1 invalid while unlocked -> 1-high/7-low slip, headers ignored
        for (int i = 0; i < 10; i++) begin drv_a(1, 2'b10); tick(); end
        drv_a(1, 2'b11);
        push(cyc + 1, 0, 1, K_SLIP, 1);
        push(cyc + 2, 0, 1, K_SLIP, 0);
        tick();
        for (int i = 0; i < 5; i++) begin drv_a(1, 2'b01); tick(); end
        repeat (3) tick();
        for (int i = 0; i < 64; i++) begin
            drv_a(1, 2'b01);
            if (i == 63) push(cyc + 1, 0, 1, K_LOCK, 1);
            tick();
        end

        // lanes 2,3 lock together -> all-locked
        for (int i = 0; i < 64; i++) begin
            drv_a(2, 2'b01); drv_a(3, 2'b10);
            if (i == 63) begin
                push(cyc + 1, 0, 2, K_LOCK, 1);
                push(cyc + 1, 0, 3, K_LOCK, 1);
                push(cyc + 1, 0, 0, K_ALL, 1);
            end
            tick();
        end
        chk("t3_all_locked", int'(all_a), 1);

        // 3: lane2, 15 invalid in a window holds lock; 16 in the next drops it
        for (int i = 0; i < 64; i++) begin
            if (i % 4 == 0 && i < 60) h = (i % 8 == 0) ? 2'b00 : 2'b11;
            else                      h = (i % 2 == 1) ? 2'b10 : 2'b01;
            drv_a(2, h);
            tick();
        end
        chk("t3_lock_held", int'(lock_a), 4'b1111);
        for (int i = 0; i < 62; i++) begin
            h = (i % 4 == 1) ? 2'b11 : 2'b01;
            drv_a(2, h);
            if (i == 61) begin
                push(cyc + 1, 0, 2, K_LOCK, 0);
                push(cyc + 1, 0, 2, K_SLIP, 1);
                push(cyc + 1, 0, 2, K_LOST, 1);
                push(cyc + 1, 0, 2, K_CNT,  1);
                push(cyc + 1, 0, 0, K_ALL,  0);
                push(cyc + 2, 0, 2, K_SLIP, 0);
                push(cyc + 2, 0, 2, K_LOST, 0);
            end
            tick();
        end
        repeat (10) tick();
        chk("t3_cnt2", int'(cnt_a[23:16]), 1);

        // 4: lane3, 16th invalid header is the window-end header
        for (int i = 0; i < 64; i++) begin
            h = (i >= 48) ? 2'b00 : 2'b01;
            drv_a(3, h);
            if (i == 63) begin
                push(cyc + 1, 0, 3, K_LOCK, 0);
                push(cyc + 1, 0, 3, K_SLIP, 1);
                push(cyc + 1, 0, 3, K_LOST, 1);
                push(cyc + 1, 0, 3, K_CNT,  1);
                push(cyc + 2, 0, 3, K_SLIP, 0);
                push(cyc + 2, 0, 3, K_LOST, 0);
            end
            tick();
        end
        repeat (10) tick();
        chk("t4_cnt3", int'(cnt_a[31:24]), 1);

        // 5: DUT B lane1, five lock losses on a 2-bit saturating counter
        for (int n = 1; n <= 5; n++) begin
            for (int i = 0; i < 64; i++) begin
                drv_b(1, 2'b01);
                if (i == 63) push(cyc + 1, 1, 1, K_LOCK, 1);
                tick();
            end
            for (int j = 0; j < 16; j++) begin
                drv_b(1, 2'b00);
                if (j == 15) begin
                    push(cyc + 1, 1, 1, K_LOCK, 0);
                    push(cyc + 1, 1, 1, K_SLIP, 1);
                    push(cyc + 1, 1, 1, K_LOST, 1);
                    if (n <= 3) push(cyc + 1, 1, 1, K_CNT, n);
                    push(cyc + 2, 1, 1, K_LOST, 0);
                    push(cyc + 5, 1, 1, K_SLIP, 0);
                end
                tick();
            end
            repeat (12) tick();
            chk($sformatf("t5_cnt_loss%0d", n), int'(cnt_b[3:2]), (n < 3) ? n : 3);
        end

        // 6: reset during a 4-cycle slip pulse, then lock on strobes not cycles
        drv_b(0, 2'b11);
        push(cyc + 1, 1, 0, K_SLIP, 1);
        tick();
        tick();
        chk("t6_slip_high", int'(slip_b[0]), 1);
        rst_b = 1;
        push(cyc + 1, 1, 0, K_SLIP, 0);
        push(cyc + 1, 1, 1, K_CNT,  0);
        tick();
        rst_b = 0;
        chk("t6_rst_slip", int'(slip_b), 0);
        chk("t6_rst_lock", int'(lock_b), 0);
        chk("t6_rst_lost", int'(lost_b), 0);
        chk("t6_rst_cnt",  int'(cnt_b),  0);
        chk("t6_rst_all",  int'(all_b),  0);
        for (int i = 0; i < 128; i++) begin
            if (i % 2 == 0) drv_b(0, 2'b01);
            if (i == 126) push(cyc + 1, 1, 0, K_LOCK, 1);
            tick();
        end
        chk("t6_lock0", int'(lock_b), 2'b01);

        repeat (5) tick();
        mon_en = 0;
        reap(32'h7fff_ffff);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/taxi_eth_phy_rx_frame_sync_ml.md
Name: taxi_eth_phy_rx_frame_sync_ml

Overview:
Multi-lane, parametrised block-sync (frame sync) for 10G/25G/40G/100G BASE-R receive paths. It sits between the per-lane SERDES gearbox and the descrambler/lane-alignment logic. Each lane runs an independent Clause 49/82-style sync-header lock machine and drives its own bitslip. Generalisations: lane count, window length, invalid threshold, per-lane lock-loss statistics, and an all-lanes-locked status.

Parameters:
LANES, 4, number of independent lanes (>=1)
HDR_W, 2, sync header width; must be 2, otherwise $fatal at elaboration
SH_WIN, 64, headers per test window; power of 2, 4..1024
SH_INV_MAX, 16, invalid headers within one window that drop lock; 1..SH_WIN
BITSLIP_HIGH_CYCLES, 1, bitslip pulse width in clk cycles (>=1)
BITSLIP_LOW_CYCLES, 7, minimum low/guard time after each pulse (>=0)
STAT_CNT_W, 8, width of per-lane lock-loss counter

Ports:
clk  in  1  block clock
rst  in  1  synchronous active-high reset
serdes_rx_hdr  in  LANES*HDR_W  sync headers; lane n at [n*2 +: 2]
serdes_rx_hdr_valid  in  LANES  per-lane header strobe
serdes_rx_bitslip  out  LANES  per-lane slip request to SERDES
rx_block_lock  out  LANES  per-lane block lock
rx_block_lock_all  out  1  AND of all rx_block_lock bits
stat_lock_lost  out  LANES  one-cycle pulse when a locked lane loses lock
stat_lock_loss_cnt  out  LANES*STAT_CNT_W  saturating lock-loss count per lane

Behaviour:
- Reset: all outputs 0; all counters and timers 0; every lane unlocked. Reset wins over any in-flight slip; bitslip is 0 on the cycle after rst is sampled.
- Valid header: 2'b01 or 2'b10. Invalid: 2'b00 or 2'b11.
- Per-lane registers: sh_count [$clog2(SH_WIN)], sh_inv_count [$clog2(SH_INV_MAX+1)], slip timer, bitslip, lock, stat counter.
- Slip sequencer (priority 1): when triggered, bitslip=1 for BITSLIP_HIGH_CYCLES, then 0 for BITSLIP_LOW_CYCLES.
  - Headers are ignored for the whole high+low span.
  - The timer counts every clk, independent of hdr_valid.
- No header (priority 2): hdr_valid=0 and slip idle -> lane state holds.
- UNLOCKED with header:
  - Valid -> sh_count++.
  - When the header sampled with sh_count==SH_WIN-1 is valid, lock=1 on the next cycle; sh_count and sh_inv_count clear to 0.
  - Invalid -> clear counts and trigger a slip; bitslip rises on the next cycle.
- LOCKED with header:
  - Every header -> sh_count++.
  - Invalid header -> sh_inv_count++.
  - If an invalid header makes sh_inv_count reach SH_INV_MAX: lock=0 next cycle, counts clear, slip triggers, stat_lock_lost pulses 1 cycle, and the stat counter increments.
  - Otherwise, when the header sampled with sh_count==SH_WIN-1 is processed, both counts clear (window end) and lock stays 1.
  - If the SH_INV_MAX-th invalid header lands on the window-end header, lock loss wins.
- sh_count wraps to 0 modulo SH_WIN. No other arithmetic overflow is possible.
- stat_lock_loss_cnt saturates at all-ones and clears only on rst.
- rx_block_lock_all is combinational AND of the registered lock bits, so it adds no extra latency.
- Lanes are fully independent; no shared state except the rx_block_lock_all reduction.
- Latency: header sample to lock/bitslip/stat update is 1 cycle.

Test Plan:
1. Defaults, lane0 fed 64 consecutive 2'b01 with hdr_valid=1 every cycle -> rx_block_lock[0]=1 exactly 1 cycle after the 64th header; lanes 1-3 stay 0; rx_block_lock_all=0.
2. Unlocked lane fed 2'b11 -> bitslip high 1 cycle, low 7 cycles; 5 valid headers presented during those 8 cycles do not advance sh_count. Lock then needs 64 further valid headers.
3. All lanes locked (rx_block_lock_all=1); lane2 gets 15 invalid headers in a 64-header window -> lock held and window resets. Next window, 16 invalid -> rx_block_lock[2]=0, stat_lock_lost[2] 1-cycle pulse, stat_lock_loss_cnt lane2=1, bitslip[2] pulses, rx_block_lock_all=0.
4. Locked lane, 16th invalid header is the window-end (64th) header -> lock lost and the stat counter increments.
5. STAT_CNT_W=2, force 5 lock losses on lane1 -> count reads 1,2,3,3,3.
6. Assert rst during a bitslip high phase (BITSLIP_HIGH_CYCLES=4) -> bitslip 0 and all outputs 0 next cycle; with hdr_valid toggling 1/0, lock requires 64 valid strobes, not 64 cycles.
